// File: rtl/l2_request_arbiter.sv
// l2_request_arbiter: registered IF/MEM arbiter in front of the unified L2.
// MEM wins contention except when IF has lost STARVE_LIMIT contended rounds
// in a row. The grant is held until l2_resp, followed by one idle cycle.
module l2_request_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [15:0]  IF_address,
  input  logic         IF_read,
  input  logic         IF_write,
  input  logic [127:0] IF_wdata,
  input  logic [15:0]  MEM_address,
  input  logic         MEM_read,
  input  logic         MEM_write,
  input  logic [127:0] MEM_wdata,
  input  logic         l2_resp,
  input  logic [127:0] l2_rdata,
  output logic         l2i_resp,
  output logic [127:0] l2i_rdata,
  output logic         l2d_resp,
  output logic [127:0] l2d_rdata,
  output logic [15:0]  l2_address,
  output logic         l2_read,
  output logic         l2_write,
  output logic [127:0] l2_wdata,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t       state_q, state_d;
  logic [15:0]  addr_q, addr_d;
  logic         rd_q, rd_d;
  logic         wr_q, wr_d;
  logic [127:0] wdata_q, wdata_d;
  logic [3:0]   streak_q, streak_d;

  logic req_i;
  logic req_d;

  assign req_i = IF_read | IF_write;
  assign req_d = MEM_read | MEM_write;

  // Next-state, grant selection, command latching and starvation streak.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    wdata_d  = wdata_q;
    streak_d = streak_q;
    case (state_q)
      IDLE: begin
        if (req_i && (!req_d || streak_q == LIMIT)) begin
          state_d  = GRANT_I;
          addr_d   = IF_address;
          wdata_d  = IF_wdata;
          wr_d     = IF_write;
          rd_d     = IF_read & ~IF_write;
          streak_d = '0;
        end else if (req_d) begin
          state_d  = GRANT_D;
          addr_d   = MEM_address;
          wdata_d  = MEM_wdata;
          wr_d     = MEM_write;
          rd_d     = MEM_read & ~MEM_write;
          if (req_i) begin
            streak_d = (streak_q == LIMIT) ? LIMIT : streak_q + 4'd1;
          end else begin
            streak_d = '0;
          end
        end
      end
      GRANT_I, GRANT_D: begin
        if (l2_resp) begin
          state_d = IDLE;
          addr_d  = '0;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          wdata_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and L2 command registers; reset abandons any transfer in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      wdata_q  <= wdata_d;
      streak_q <= streak_d;
    end
  end

  assign l2_address = addr_q;
  assign l2_read    = rd_q;
  assign l2_write   = wr_q;
  assign l2_wdata   = wdata_q;
  assign busy       = (state_q != IDLE);

  assign l2i_resp  = l2_resp & (state_q == GRANT_I);
  assign l2d_resp  = l2_resp & (state_q == GRANT_D);
  assign l2i_rdata = (state_q == GRANT_I) ? l2_rdata : '0;
  assign l2d_rdata = (state_q == GRANT_D) ? l2_rdata : '0;

endmodule

// File: doc/l2_request_arbiter.md
# l2_request_arbiter

Registered two-requester arbiter between the split L1 caches (instruction-fetch side and MEM side) and the unified L2 cache. A request is granted from IDLE, and its address, write data and command are latched. The grant is held until L2 returns `l2_resp`, which is routed back only to the granted L1. The MEM side has fixed priority, bounded by a starvation counter that forces an IF grant after `STARVE_LIMIT` consecutive MEM grants taken while IF was waiting.

## Interface
- `STARVE_LIMIT`, default 4: consecutive contended MEM grants after which a pending IF request wins; legal range 1–15.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `IF_address` in 16 (`lc3b_word`): IF-side line address.
- `IF_read`, `IF_write` in 1 each: IF-side command.
- `IF_wdata` in 128 (`lc3b_burst`): IF-side write line.
- `MEM_address` in 16: MEM-side line address.
- `MEM_read`, `MEM_write` in 1 each: MEM-side command.
- `MEM_wdata` in 128: MEM-side write line.
- `l2_resp` in 1: L2 transfer complete, one-cycle pulse.
- `l2_rdata` in 128: L2 read line, valid while `l2_resp` is high.
- `l2i_resp` out 1: response to IF side.
- `l2i_rdata` out 128: read data to IF side.
- `l2d_resp` out 1: response to MEM side.
- `l2d_rdata` out 128: read data to MEM side.
- `l2_address` out 16: registered L2 address.
- `l2_read`, `l2_write` out 1 each: registered L2 command.
- `l2_wdata` out 128: registered L2 write line.
- `busy` out 1: high in GRANT_I or GRANT_D.

## Operation
- **States:** IDLE, GRANT_I, GRANT_D. Encoded state, latched command/address/wdata and streak counter are the only storage.
- **Requests:** `req_i = IF_read | IF_write`; `req_d = MEM_read | MEM_write`.
- **Command reduction:** if a requester asserts both read and write, the latched command is write only.
- **IDLE, no request:** stay in IDLE.
- **IDLE, `req_d` only:** go to GRANT_D.
- **IDLE, `req_i` only:** go to GRANT_I.
- **IDLE, both requesting:**
  - go to GRANT_I if `streak == STARVE_LIMIT`;
  - otherwise go to GRANT_D.
- **On each grant edge:** latch the winner's address, wdata and command into the `l2_*` output registers.
- **GRANT_x:** hold every `l2_*` output constant; ignore requester inputs. When `l2_resp == 1`, return to IDLE and clear `l2_read`, `l2_write`, `l2_address` and `l2_wdata` to 0.
- **Response routing (combinational):**
  - `l2i_resp = l2_resp & (state == GRANT_I)`; `l2i_rdata = l2_rdata` in GRANT_I, else 0.
  - `l2d_resp = l2_resp & (state == GRANT_D)`; `l2d_rdata = l2_rdata` in GRANT_D, else 0.
  - `l2_resp` arriving in IDLE is dropped.
- **Streak counter (4 bits):**
  - increments on a GRANT_D entry while `req_i == 1`, saturating at `STARVE_LIMIT`;
  - clears on any GRANT_I entry;
  - clears on a GRANT_D entry while `req_i == 0`.
- **Turnaround:** the IDLE cycle after a response is mandatory. The finishing L1 deasserts its command during that cycle, so a stale request is never re-granted.
- **Reset:** `rst_n == 0` asynchronously forces state to IDLE, streak to 0 and every registered output to 0, including mid-grant. A transfer in flight is abandoned; the L1 must reissue it.

## Timing
- **Reset values:** all outputs 0; `busy` 0.
- **Grant latency:** request seen in IDLE at cycle N → `l2_read`/`l2_write` and `busy` high from cycle N+1.
- **Return latency:** `l2_resp` at cycle M → routed response in cycle M (zero latency); IDLE and outputs cleared from M+1. Earliest next grant is visible at M+2.
- **Minimum request-to-response:** request at N, `l2_resp` at N+1 gives response at N+1, 2 cycles total.
- **Simultaneous events:**
  - A new request arriving in the cycle of `l2_resp` is not granted until after the IDLE cycle.
  - Requester inputs changing mid-grant do not affect `l2_*` outputs.

## Test plan
- **Single IF read:** reset, then `IF_read=1`, `IF_address=16'h1230`; `l2_resp` 3 cycles after grant with `l2_rdata=128'hA5…` → `l2_read=1`, `l2_address=16'h1230` one cycle after request; `l2i_resp=1` with `l2i_rdata=128'hA5…` in the response cycle; `l2d_resp=0`; `busy=0` the next cycle.
- **Contention:** `IF_read` and `MEM_write` (`MEM_address=16'h4000`) asserted together → `l2_write=1`, `l2_address=16'h4000` first; after that `l2_resp`, IDLE for one cycle, then IF granted.
- **Starvation (`STARVE_LIMIT=4`):** `IF_read` and `MEM_read` asserted continuously → 4 D grants, then an I grant. Streak reads 0 after the I grant and the pattern repeats.
- **Input changes mid-grant:** during GRANT_D, change `MEM_address` and `MEM_wdata` → `l2_address` and `l2_wdata` unchanged until `l2_resp`.
- **Stray response:** `l2_resp` pulsed in IDLE → `l2i_resp` and `l2d_resp` stay 0; no state change.
- **Reset mid-grant:** `rst_n` low mid-GRANT_I, released with no requests pending → all outputs 0 immediately; IDLE after release; a subsequent `MEM_read` is granted normally with streak 0.
